// File: rtl/sound_scheduler_pkg.sv
// rtl/sound_scheduler_pkg.sv - shared state encoding and defaults for the audio scheduler
package sound_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_PLAY_SFX = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam logic [15:0] AMP_DEFAULT      = 16'd8192;
  localparam int          TICK_CYC_DEFAULT = 100000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sound_scheduler_square_gen.sv
// rtl/sound_scheduler_square_gen.sv - square-wave phase generator, half-period of div clk cycles
module square_gen #(
  parameter int DIV_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             silent
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_prev;
  logic             r_phase;

  // A changed div restarts the count but keeps the phase, so retuning does not click.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div_prev <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_div_prev <= div;
      if (clr || (div == '0)) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (div != r_div_prev) begin
        r_cnt <= '0;
      end else if (r_cnt == (div - DIV_W'(1))) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign phase  = r_phase;
  assign silent = (div == '0);

endmodule

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - fixed-priority sharing of one PCM output between music and one-shot effects
module sound_scheduler
  import sound_scheduler_pkg::*;
#(
  parameter int          NUM_SFX   = 2,
  parameter int          DIV_W     = 22,
  parameter int          DUR_W     = 8,
  parameter int          TICK_CYC  = TICK_CYC_DEFAULT,
  parameter int          GAP_TICKS = 2,
  parameter logic [15:0] AMP       = AMP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mute,
  input  logic [DIV_W-1:0]         bgm_div,
  input  logic [NUM_SFX-1:0]       sfx_req,
  input  logic [NUM_SFX*DIV_W-1:0] sfx_div,
  input  logic [NUM_SFX*DUR_W-1:0] sfx_dur,
  output logic [NUM_SFX-1:0]       sfx_ack,
  output logic                     busy,
  output logic [15:0]              audio_left,
  output logic [15:0]              audio_right
);

  localparam int TICK_W = cnt_width(TICK_CYC);
  localparam int IDX_W  = cnt_width(NUM_SFX);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   w_first_idx;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_gdiv;
  logic [DIV_W-1:0]   w_sq_div;
  logic [DUR_W-1:0]   r_rem;
  logic [DUR_W-1:0]   w_gdur;
  logic [TICK_W-1:0]  r_tick;
  logic [15:0]        r_sample;
  logic [NUM_SFX-1:0] w_ack;
  logic               w_busy;
  logic               w_tick_wrap;
  logic               w_last_tick;
  logic               w_clr;
  logic               w_phase;
  logic               w_silent;
  logic               w_quiet;

  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (sfx_req[i]) w_first_idx = IDX_W'(i);
    end
  end

  assign w_gdiv      = sfx_div[int'(r_gidx) * DIV_W +: DIV_W];
  assign w_gdur      = sfx_dur[int'(r_gidx) * DUR_W +: DUR_W];
  assign w_tick_wrap = (r_tick == TICK_W'(TICK_CYC - 1));
  assign w_last_tick = w_tick_wrap && (r_rem == DUR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ack  = '0;
    w_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|sfx_req) w_next = ST_GRANT;
      end
      ST_GRANT: begin
        w_ack[r_gidx] = 1'b1;
        w_next        = (w_gdur == '0) ? ST_GAP : ST_PLAY_SFX;
      end
      ST_PLAY_SFX: begin
        w_busy = 1'b1;
        if (w_last_tick) w_next = ST_GAP;
      end
      ST_GAP: begin
        w_busy = 1'b1;
        if (w_last_tick) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_rem counts remaining effect ticks, then is reloaded to count the silent gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gidx <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_tick <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gidx <= w_first_idx;
          r_tick <= '0;
        end
        ST_GRANT: begin
          r_div  <= w_gdiv;
          r_rem  <= (w_gdur == '0) ? DUR_W'(GAP_TICKS) : w_gdur;
          r_tick <= '0;
        end
        default: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            r_rem  <= (w_last_tick && (r_state == ST_PLAY_SFX)) ? DUR_W'(GAP_TICKS)
                                                                : r_rem - DUR_W'(1);
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
      endcase
    end
  end

  // GAP feeds bgm_div under clear so music resumes at phase 0 without a restart stall.
  always_comb begin
    w_sq_div = bgm_div;
    case (r_state)
      ST_GRANT:    w_sq_div = w_gdiv;
      ST_PLAY_SFX: w_sq_div = r_div;
      default:     w_sq_div = bgm_div;
    endcase
  end

  assign w_clr = (r_state == ST_GRANT) || (r_state == ST_GAP);

  square_gen #(
    .DIV_W(DIV_W)
  ) u_square_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .div   (w_sq_div),
    .phase (w_phase),
    .silent(w_silent)
  );

  assign w_quiet = mute || w_silent || (r_state == ST_GRANT) || (r_state == ST_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sample <= '0;
    else if (w_quiet) r_sample <= '0;
    else              r_sample <= w_phase ? AMP : (~AMP + 16'd1);
  end

  assign sfx_ack     = w_ack;
  assign busy        = w_busy;
  assign audio_left  = r_sample;
  assign audio_right = r_sample;

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Produces the 16-bit left/right PCM sample words that drive the I2S audio serializer. It shares that single audio output between a continuous background-music source and NUM_SFX one-shot sound-effect requesters. Shared by fixed priority, no preemption.
Each selected source is rendered as a square wave of programmable half-period, with a short silent gap between an effect and the resumption of music.

Parameters:
NUM_SFX, 2, number of sound-effect requesters (index 0 = highest priority)
DIV_W, 22, width of half-period divider values (in clk cycles)
DUR_W, 8, width of effect duration field (in ticks)
TICK_CYC, 100000, clk cycles per duration tick (1 ms at 100 MHz)
GAP_TICKS, 2, silent ticks inserted after every effect
AMP, 16'd8192, square-wave amplitude; output swings +AMP / -AMP (two's complement)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mute  in  1  forces both sample outputs to 0 while high; sequencing continues
bgm_div  in  DIV_W  music half-period; 0 = rest (silence)
sfx_req  in  NUM_SFX  level request per effect; held until acked
sfx_div  in  NUM_SFX*DIV_W  flattened half-periods, slice i = [i*DIV_W +: DIV_W]
sfx_dur  in  NUM_SFX*DUR_W  flattened durations in ticks, slice i = [i*DUR_W +: DUR_W]
sfx_ack  out  NUM_SFX  one-cycle grant pulse to the winning requester
busy  out  1  high in PLAY_SFX and GAP
audio_left  out  16  sample word to serializer
audio_right  out  16  sample word to serializer; always equals audio_left

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately, including mid-effect.
  - State → IDLE.
  - Outputs: sfx_ack=0, busy=0, audio_left/right=0.
  - Internal: tick and phase counters=0, phase=0, latched div/dur=0.
- States: IDLE, GRANT, PLAY_SFX, GAP.
- IDLE: plays bgm_div. If any sfx_req bit is set → GRANT on the next edge.
- GRANT (1 cycle):
  - Picks the lowest set index i and pulses sfx_ack[i]=1 for exactly this cycle.
  - Latches sfx_div slice i and sfx_dur slice i.
  - Clears the tick counter, phase counter and phase.
  - Next state: PLAY_SFX, or GAP directly if latched dur=0.
  - Output during GRANT is 0.
- PLAY_SFX:
  - Plays the latched div.
  - Tick counter counts 0..TICK_CYC-1 and wraps. Each wrap decrements remaining dur.
  - When remaining dur reaches 0 → GAP, with tick counter cleared.
- GAP:
  - Outputs silence for GAP_TICKS ticks, then → IDLE.
  - The phase counter clears on entry to IDLE, so music restarts with phase 0.
- Requests are never acked outside IDLE.
  - A request arriving during PLAY_SFX/GAP waits.
  - No preemption, even by a higher-priority effect.
  - On return to IDLE with pending requests, IDLE lasts one cycle before GRANT.
- Square wave:
  - Phase counter runs 0..div-1. At div-1 it clears and phase toggles, so period = 2*div cycles.
  - If bgm_div changes while in IDLE, the counter restarts from 0 on the next cycle and phase is kept.
  - div=0: counter held at 0, phase=0, sample=0.
- Sample word (registered, 1-cycle latency from phase):
  - 0 if mute, div=0, GRANT or GAP.
  - Otherwise AMP when phase=1, else (~AMP+1).
- Counter width: phase counter DIV_W bits; tick counter ceil(log2(TICK_CYC)) bits.
- Simultaneous events:
  - A dur decrement to 0 coinciding with a phase toggle: the state transition wins, and the toggled phase is not output.
  - sfx_req dropping during GRANT is ignored; the grant still completes.

Decomposition:
- Shared package holds:
  - State encodings: IDLE=2'd0, GRANT=2'd1, PLAY_SFX=2'd2, GAP=2'd3.
  - Defaults for AMP and TICK_CYC.
- One sub-module: square_gen (clk, rst_n, clr, div → phase, silent), instantiated once and fed the mux-selected div.

Test Plan:
- Reset mid-effect: rst_n=0 during PLAY_SFX → audio=0, busy=0, state IDLE immediately (asynchronous); after release, music resumes.
- Music only: TICK_CYC=4, bgm_div=3, no requests → audio alternates 16'hE000 ×3 cycles, 16'h2000 ×3 cycles, period 6.
- Single effect: sfx_req=2'b10, sfx_div[1]=2, dur[1]=3 → one sfx_ack=2'b10 pulse, then 12 cycles of period-4 tone, 8 silent gap cycles, busy high throughout, then music.
- Priority: sfx_req=2'b11 together → ack 2'b01 first; req[1] held → ack 2'b10 after the first effect's gap plus one IDLE cycle.
- Edge values:
  - dur=0 → ack, then straight to the 8-cycle gap.
  - div=0 effect → silent for its full duration.
  - bgm_div=0 → audio constant 0.
- Mute: mute=1 during an effect → audio=0, while timing, ack and busy are identical to the unmuted run.
